// File: rtl/core_pkg.sv
// Shared definitions for the branch target buffer.
// Counter encodings are functions of the counter width, so one package
// serves every CTR_W:
//   ctr_snt      - strongly not taken (all zeros)
//   ctr_wt(w)    - weakly taken (MSB set, all other bits clear)
//   ctr_st(w)    - strongly taken (all ones)
package core_pkg;

  localparam logic [31:0] CTR_SNT = 32'd0;

  function automatic logic [31:0] ctr_wt(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] ctr_st(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Saturating up/down counter with a synchronous load.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (clears to 0)
//   inc, dec    - step up / step down, clamped at all-ones / zero
//   load        - load load_val; takes priority over inc and dec
//   count       - current value
module sat_counter
  import core_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic [CTR_W-1:0] count
);

  localparam logic [CTR_W-1:0] MAX_V = CTR_W'(ctr_st(CTR_W));
  localparam logic [CTR_W-1:0] MIN_V = CTR_W'(CTR_SNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      if (count != MAX_V) count <= count + 1'b1;
    end else if (dec) begin
      if (count != MIN_V) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, sitting beside fetch.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   lookup_pc          - fetch PC; pred_hit/pred_taken/pred_target are
//                        combinational from stored state
//   upd_en, upd_pc,
//   upd_taken,
//   upd_target         - resolved-branch training from execute
//   upd_mispred        - misprediction flag, counted when upd_en is high
//   flush              - invalidate all entries (wins over a same-cycle update)
//   mispred_count      - saturating misprediction statistic
module branch_target_buffer
  import core_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  input  logic              flush,
  output logic [STAT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WT = CTR_W'(ctr_wt(CTR_W));

  // Table lives in flops so the lookup can be asynchronous.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  // Lookup path
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  assign lk_idx = lookup_pc[IDX_W-1:0];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W];

  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_target = pred_hit ? target_q[lk_idx] : '0;

  // Update path; flush suppresses the whole update, including allocation.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             upd_go;
  assign up_idx = upd_pc[IDX_W-1:0];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign upd_go = upd_en && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_go && upd_taken) begin
      // Taken hit refreshes the target; taken miss overwrites the slot.
      target_q[up_idx] <= upd_target;
      if (!up_hit) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
      end
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = upd_go && (up_idx == IDX_W'(i));
    sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .inc      (sel && up_hit && upd_taken),
      .dec      (sel && up_hit && !upd_taken),
      .load     (sel && !up_hit && upd_taken),
      .load_val (CTR_WT),
      .count    (ctr_q[i])
    );
  end

  // Counts even when flush drops the update.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispred_count <= '0;
    end else if (upd_en && upd_mispred && (mispred_count != '1)) begin
      mispred_count <= mispred_count + 1'b1;
    end
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised branch target buffer and direction predictor for the pipelined 16-bit core. It sits beside the fetch stage. Each cycle it looks up the fetch PC and returns a hit flag, a taken prediction and a target. When execute resolves a branch, it trains a per-entry saturating counter and target. It replaces the fixed single-target/enable pair currently driving fetch, and adds tag matching, allocation, flush and a misprediction statistic.

## Interface
- ADDR_W, 16, PC/target width in bits (word addresses)
- ENTRIES, 16, table depth; power of two, ≥2; IDX_W = log2(ENTRIES), TAG_W = ADDR_W − IDX_W
- CTR_W, 2, direction counter width; ≥1
- STAT_W, 16, misprediction counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- lookup_pc  in  ADDR_W  fetch-stage PC
- pred_hit  out  1  valid entry with matching tag at lookup_pc
- pred_taken  out  1  predicted taken (pred_hit && counter MSB)
- pred_target  out  ADDR_W  stored target on hit, else 0
- upd_en  in  1  resolved-branch update strobe from execute
- upd_pc  in  ADDR_W  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual target (meaningful when upd_taken)
- upd_mispred  in  1  execute detected misprediction (qualified by upd_en)
- flush  in  1  invalidate all entries
- mispred_count  out  STAT_W  saturating count of qualified mispredictions

## Operation
- Entry: valid, tag[TAG_W], target[ADDR_W], ctr[CTR_W]. index = pc[IDX_W-1:0]; tag = pc[ADDR_W-1:IDX_W].
- Lookup is purely combinational from stored state. hit = valid[idx] && tag[idx]==lookup tag. pred_taken = hit && ctr[CTR_W-1]. pred_target = hit ? target : 0.
- Update (upd_en=1), with entry at upd_pc index:
  - Hit, taken: ctr saturating +1 (max 2^CTR_W−1); target ← upd_target.
  - Hit, not taken: ctr saturating −1 (min 0); target unchanged.
  - Miss, taken: allocate and overwrite the slot: valid←1, tag, target←upd_target, ctr←WT (weakly taken: MSB set, other bits 0).
  - Miss, not taken: no change.
- mispred_count increments by 1 when upd_en && upd_mispred, saturating at all-ones.
- flush clears every valid bit; targets, counters and mispred_count are untouched.
- Reset clears all valid bits, targets, counters and mispred_count to 0. After reset: pred_hit=0, pred_taken=0, pred_target=0.

## Timing
- Lookup latency 0 cycles (combinational). Update latency 1 cycle: visible to lookup the cycle after the upd_en edge.
- Lookup and update on the same index in the same cycle: lookup returns the pre-update contents.
- flush and upd_en in the same cycle: flush wins; the update is dropped, including allocation. mispred_count still increments.
- reset dominates flush and upd_en.
- Aliasing: two PCs with the same index and different tags evict each other on taken-miss allocation; no replacement policy beyond overwrite.
- Counter wrap is forbidden: saturation at both ends. mispred_count holds at max.

## Structure
- A shared core_pkg holds CTR_WT/CTR_ST/CTR_SNT encodings as functions of CTR_W, plus the entry struct typedef.
- One sub-module: sat_counter (parametrised CTR_W, inc/dec/load inputs). Instantiate it per entry, or once on the update path with registered array storage.
- Table storage is flops, not inferred RAM, because lookup is asynchronous.

## Test plan
- Reset, then lookup_pc=0x0040 → pred_hit=0, pred_taken=0, pred_target=0, mispred_count=0.
- Update pc=0x0043 taken, target 0x0100 → next cycle lookup 0x0043: hit=1, taken=1, target=0x0100. Lookup 0x0013 (same index, other tag) → hit=0.
- Train 0x0043: taken ×3, then not-taken ×1 → taken=1. One further not-taken → taken=0, hit=1. Five further not-takens → ctr stays 0.
- Same cycle: lookup and update on 0x0043 → old prediction on that cycle, new one on the next.
- flush together with a taken update to 0x0050 → next cycle both 0x0043 and 0x0050 miss. upd_mispred=1 with upd_en=1 → count+1; upd_mispred=1 with upd_en=0 → no change.
- STAT_W=4: 20 qualified mispredictions → mispred_count=15. Reset mid-run → all outputs return to reset values the next cycle.
